// File: rtl/log_pkg.sv
// Shared definitions for log_unit: operation codes and FSM state encoding.
package log_pkg;

  localparam logic [2:0] OP_NAND = 3'd0;
  localparam logic [2:0] OP_NOR  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_ROR  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/log_shifter.sv
// Iterative one-bit-per-cycle shifter/rotator with down-counter; done is high
// whenever the remaining count is zero.
module log_shifter #(
  parameter int WIDTH = 16,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             ror,
  input  logic [WIDTH-1:0] data,
  input  logic [SH_W-1:0]  amount,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  logic [WIDTH-1:0] work;
  logic [SH_W-1:0]  count;

  always_ff @(posedge clk) begin
    if (rst) begin
      work  <= '0;
      count <= '0;
    end else if (load) begin
      work  <= data;
      count <= amount;
    end else if (step && (count != '0)) begin
      work  <= ror ? {work[0], work[WIDTH-1:1]} : {work[WIDTH-2:0], 1'b0};
      count <= count - 1'b1;
    end
  end

  assign result = work;
  assign done   = (count == '0);

endmodule

// File: rtl/log_unit.sv
// Multi-cycle logic unit: IDLE/EXEC/DONE FSM, eight ops, zero/err flags, tri-state result bus.
// Define LOG_SHIFT_EN to build the iterative SHL/ROR shifter; otherwise ops 6/7 are illegal.
module log_unit
  import log_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic [2:0]       op_sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] out_d,
  output logic             rdy,
  output logic             zero,
  output logic             err,
  output state_t           fsm_state
);

  // Handshake: a request is accepted when cs=1 at an edge where the unit is in IDLE
  // (rdy=1); rdy drops for EXEC, and out_d is driven only during the single DONE cycle.

  state_t           state, state_next;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             zero_q, err_q;
  logic             accept, finish, shift_op, shift_wait;
  logic [WIDTH-1:0] exec_res;
  logic             exec_err;

  assign accept   = (state == ST_IDLE) && cs;
  assign shift_op = (op_q == OP_SHL) || (op_q == OP_ROR);
  assign finish   = (state == ST_EXEC) && !shift_wait;

`ifdef LOG_SHIFT_EN
  logic [WIDTH-1:0] shift_res;
  logic             shift_done;

  // Loaded straight from the ports on the accept edge, alongside the operand capture.
  log_shifter #(.WIDTH(WIDTH), .SH_W(SH_W)) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   ((state == ST_EXEC) && shift_op),
    .ror    (op_q == OP_ROR),
    .data   (A),
    .amount (B[SH_W-1:0]),
    .result (shift_res),
    .done   (shift_done)
  );

  assign shift_wait = shift_op && !shift_done;
`else
  assign shift_wait = 1'b0;
`endif

  always_comb begin
    exec_res = '0;
    exec_err = 1'b0;
    case (op_q)
      OP_NAND: exec_res = ~(a_q & b_q);
      OP_NOR:  exec_res = ~(a_q | b_q);
      OP_XOR:  exec_res = a_q ^ b_q;
      OP_NOT:  exec_res = ~a_q;
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      default: begin
`ifdef LOG_SHIFT_EN
        exec_res = shift_res;
`else
        exec_err = 1'b1;
`endif
      end
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (cs) state_next = ST_EXEC;
      ST_EXEC: if (!shift_wait) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q <= op_sub;
        a_q  <= A;
        b_q  <= B;
      end
      if (finish) begin
        res_q  <= exec_res;
        zero_q <= (exec_res == '0);
        err_q  <= exec_err;
      end
    end
  end

  assign out_d     = (state == ST_DONE) ? res_q : 'z;
  assign rdy       = (state != ST_EXEC);
  assign zero      = zero_q;
  assign err       = err_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_log_unit.sv
// Directed table-driven bench for log_unit (WIDTH=16); expectations follow LOG_SHIFT_EN.
module tb_log_unit;
  import log_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic [2:0]  op_sub = '0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  wire  [15:0] out_d;
  logic        rdy, zero, err;
  state_t      fsm_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_out;
    int          exp_cyc;
    logic        exp_zero;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  log_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cs(cs), .op_sub(op_sub), .A(A), .B(B),
    .out_d(out_d), .rdy(rdy), .zero(zero), .err(err), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Two-state simulators read an undriven bus as zero, so zero is accepted alongside z.
  function automatic logic released();
    return (out_d === 16'bz) || (out_d === 16'h0000);
  endfunction

  task automatic check_released(input string name);
    total++;
    if (!released()) begin
      bad++;
      $display("FAIL %s actual=%0h required=zzzz", name, out_d);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] o, input int c, input logic z, input logic e);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp_out = o; v.exp_cyc = c; v.exp_zero = z; v.exp_err = e;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string name);
    int cyc;
    @(negedge clk);
    check({name, ".rdy_idle"}, rdy, 1'b1);
    cs = 1'b1; op_sub = v.op; A = v.a; B = v.b;
    @(posedge clk);
    @(negedge clk);
    cs = 1'b0;
    A = 16'($urandom); B = 16'($urandom); op_sub = 3'($urandom_range(0, 7));
    cyc = 0;
    while (rdy !== 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check({name, ".exec_cycles"}, cyc, v.exp_cyc);
    check({name, ".out"}, out_d, v.exp_out);
    check({name, ".zero"}, zero, v.exp_zero);
    check({name, ".err"}, err, v.exp_err);
    @(negedge clk);
    check_released({name, ".out_hiz"});
    check({name, ".rdy_after"}, rdy, 1'b1);
  endtask

  initial begin
    logic stale;
    vecs.push_back(mk(OP_NAND, 16'hF0F0, 16'hFF00, 16'h0FFF, 1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_NOR,  16'h0F0F, 16'h00F0, 16'hF000, 1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_XOR,  16'h1234, 16'h1234, 16'h0000, 1, 1'b1, 1'b0));
    vecs.push_back(mk(OP_NOT,  16'h0000, 16'h5555, 16'hFFFF, 1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_AND,  16'h12F0, 16'hFF0F, 16'h1200, 1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_OR,   16'h1200, 16'h0034, 16'h1234, 1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_AND,  16'hA5A5, 16'h5A5A, 16'h0000, 1, 1'b1, 1'b0));
`ifdef LOG_SHIFT_EN
    vecs.push_back(mk(OP_SHL,  16'h0001, 16'h0004, 16'h0010, 5,  1'b0, 1'b0));
    vecs.push_back(mk(OP_ROR,  16'h0001, 16'hFFF3, 16'h2000, 4,  1'b0, 1'b0));
    vecs.push_back(mk(OP_SHL,  16'hBEEF, 16'h0010, 16'hBEEF, 1,  1'b0, 1'b0));
    vecs.push_back(mk(OP_ROR,  16'h8001, 16'h0001, 16'hC000, 2,  1'b0, 1'b0));
    vecs.push_back(mk(OP_SHL,  16'h8000, 16'h0001, 16'h0000, 2,  1'b1, 1'b0));
    vecs.push_back(mk(OP_SHL,  16'hFFFF, 16'h000F, 16'h8000, 16, 1'b0, 1'b0));
`else
    vecs.push_back(mk(OP_SHL,  16'h0001, 16'h0004, 16'h0000, 1, 1'b1, 1'b1));
    vecs.push_back(mk(OP_ROR,  16'h00FF, 16'hFFF3, 16'h0000, 1, 1'b1, 1'b1));
    vecs.push_back(mk(OP_SHL,  16'hBEEF, 16'h0010, 16'h0000, 1, 1'b1, 1'b1));
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.rdy", rdy, 1'b1);
    check("reset.zero", zero, 1'b0);
    check("reset.err", err, 1'b0);
    check("reset.state", fsm_state, ST_IDLE);
    check_released("reset.out_hiz");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // cs held high: ignored in EXEC/DONE, re-accepted at the edge that samples IDLE
    @(negedge clk);
    cs = 1'b1; op_sub = OP_SHL; A = 16'hBEEF; B = 16'h0010;
    @(posedge clk);
    @(negedge clk);
    check("cs_hold.rdy_exec", rdy, 1'b0);
    op_sub = OP_NAND; A = 16'h0000; B = 16'h0003;
    @(posedge clk);
    @(negedge clk);
    check("cs_hold.rdy_done", rdy, 1'b1);
`ifdef LOG_SHIFT_EN
    check("cs_hold.out", out_d, 16'hBEEF);
`else
    check("cs_hold.out", out_d, 16'h0000);
    check("cs_hold.err", err, 1'b1);
`endif
    @(posedge clk);
    @(negedge clk);
    check("cs_hold.rdy_idle", rdy, 1'b1);
    check_released("cs_hold.out_hiz");
    @(posedge clk);
    @(negedge clk);
    check("cs_hold.rdy_reaccept", rdy, 1'b0);
    cs = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("cs_hold.second_out", out_d, 16'hFFFF);
    check("cs_hold.second_err", err, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_released("cs_hold.second_hiz");

    // Reset in EXEC of a 10-step shift: result discarded, no DONE follows
    cs = 1'b1; op_sub = OP_SHL; A = 16'h0000; B = 16'h000A;
    @(posedge clk);
    @(negedge clk);
    cs = 1'b0;
    check("rst_mid.rdy_exec", rdy, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid.rdy", rdy, 1'b1);
    check("rst_mid.zero", zero, 1'b0);
    check("rst_mid.err", err, 1'b0);
    check("rst_mid.state", fsm_state, ST_IDLE);
    check_released("rst_mid.out_hiz");
    stale = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (zero !== 1'b0 || err !== 1'b0 || rdy !== 1'b1 || fsm_state !== ST_IDLE || !released())
        stale = 1'b1;
    end
    check("rst_mid.no_done", stale, 1'b0);

    run_vec(vecs[0], "post_rst_nand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
